// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types and constants for the load/store unit.
// Rev    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   localparam int LSU_XLEN = 64;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_LO = 3'd1,
      S_RD_HI = 3'd2,
      S_WR_LO = 3'd3,
      S_WR_HI = 3'd4,
      S_RESP  = 3'd5,
      S_ERR   = 3'd6
   } lsu_state_t;

   localparam logic [2:0] F3_LB      = 3'b000;
   localparam logic [2:0] F3_LH      = 3'b001;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_LD      = 3'b011;
   localparam logic [2:0] F3_LBU     = 3'b100;
   localparam logic [2:0] F3_LHU     = 3'b101;
   localparam logic [2:0] F3_LWU     = 3'b110;
   localparam logic [2:0] F3_ILLEGAL = 3'b111;

   localparam logic [2:0] MEM_WR_B  = 3'd0;
   localparam logic [2:0] MEM_WR_H  = 3'd1;
   localparam logic [2:0] MEM_WR_W  = 3'd2;
   localparam logic [2:0] MEM_WR_D  = 3'd3;
   localparam logic [2:0] MEM_RD_DW = 3'd6;

   function automatic logic [3:0] f3_nbytes(input logic [1:0] sz);
      return 4'd1 << sz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module : lsu_if
// Brief  : Request/response handshake plus doubleword memory port of the LSU.
// Rev    : 1.0 - initial release
// ============================================================================
interface lsu_if
   import lsu_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_funct3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_err;
   logic            MEM_V;
   logic            r_w;
   logic [2:0]      size;
   logic [XLEN-1:0] address;
   logic [XLEN-1:0] data_in;
   logic [XLEN-1:0] data_out;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output MEM_V, r_w, size, address, data_in,
      input  data_out
   );

   modport mem (
      input  MEM_V, r_w, size, address, data_in,
      output data_out
   );

endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Byte-lane extract/extend for loads and masked merge for stores.
// Rev    : 1.0 - initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = LSU_XLEN
) (
   input  wire logic [2*XLEN-1:0] i_line,
   input  wire logic [2:0]        i_off,
   input  wire logic [2:0]        i_funct3,
   input  wire logic [XLEN-1:0]   i_wdata,
   output logic      [XLEN-1:0]   o_rdata,
   output logic      [2*XLEN-1:0] o_merged
);

   logic [5:0]        w_sh;
   logic [2*XLEN-1:0] w_shifted;
   logic [XLEN-1:0]   w_raw;
   logic              w_sx;
   logic [2*XLEN-1:0] w_mask_base;
   logic [2*XLEN-1:0] w_mask;
   logic [2*XLEN-1:0] w_data;

   assign w_sh      = {i_off, 3'b000};
   assign w_shifted = i_line >> w_sh;
   assign w_raw     = w_shifted[XLEN-1:0];
   assign w_sx      = ~i_funct3[2];

   always_comb begin
      o_rdata     = w_raw;
      w_mask_base = {{XLEN{1'b0}}, {XLEN{1'b1}}};
      case (i_funct3[1:0])
         2'd0: begin
            o_rdata     = {{(XLEN-8){w_sx & w_raw[7]}}, w_raw[7:0]};
            w_mask_base = {{(2*XLEN-8){1'b0}}, 8'hFF};
         end
         2'd1: begin
            o_rdata     = {{(XLEN-16){w_sx & w_raw[15]}}, w_raw[15:0]};
            w_mask_base = {{(2*XLEN-16){1'b0}}, 16'hFFFF};
         end
         2'd2: begin
            o_rdata     = {{(XLEN-32){w_sx & w_raw[31]}}, w_raw[31:0]};
            w_mask_base = {{(2*XLEN-32){1'b0}}, 32'hFFFF_FFFF};
         end
         default: begin
            o_rdata     = w_raw;
            w_mask_base = {{XLEN{1'b0}}, {XLEN{1'b1}}};
         end
      endcase
   end

   assign w_mask   = w_mask_base << w_sh;
   assign w_data   = {{XLEN{1'b0}}, i_wdata} << w_sh;
   assign o_merged = (i_line & ~w_mask) | (w_data & w_mask);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : Memory-stage LSU: aligned doubleword reads, RMW stores, split crossings.
// Rev    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN     = LSU_XLEN,
   parameter bit SPLIT_EN = 1'b1
) (
   input  wire logic CLK,
   input  wire logic RESET,
   lsu_if.slave      bus
);

   lsu_state_t        r_state;
   lsu_state_t        w_state_nxt;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic              r_cross;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_hi;

   logic              w_accept;
   logic [3:0]        w_nbytes_in;
   logic              w_cross_in;
   logic              w_illegal;
   logic [XLEN-1:0]   w_base;
   logic [XLEN-1:0]   w_base_hi;
   logic [XLEN-1:0]   w_ext;
   logic [2*XLEN-1:0] w_merged;

   assign w_accept    = bus.req_valid && (r_state == S_IDLE);
   assign w_nbytes_in = f3_nbytes(bus.req_funct3[1:0]);
   assign w_cross_in  = ({1'b0, bus.req_addr[2:0]} + w_nbytes_in) > 4'd8;
   assign w_illegal   = (bus.req_funct3 == F3_ILLEGAL)
                     || (bus.req_we && bus.req_funct3[2])
                     || (w_cross_in && !SPLIT_EN);
   assign w_base      = {r_addr[XLEN-1:3], 3'b000};
   assign w_base_hi   = w_base + XLEN'(8);

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_line   ({r_hi, r_lo}),
      .i_off    (r_addr[2:0]),
      .i_funct3 (r_funct3),
      .i_wdata  (r_wdata),
      .o_rdata  (w_ext),
      .o_merged (w_merged)
   );

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_we     <= 1'b0;
         r_funct3 <= 3'd0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_cross  <= 1'b0;
      end else if (w_accept) begin
         r_we     <= bus.req_we;
         r_funct3 <= bus.req_funct3;
         r_addr   <= bus.req_addr;
         r_wdata  <= bus.req_wdata;
         r_cross  <= w_cross_in;
      end
   end

   // Both halves stay stable through the write states so the merge is constant there.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_lo <= '0;
         r_hi <= '0;
      end else begin
         if (r_state == S_RD_LO) r_lo <= bus.data_out;
         if (r_state == S_RD_HI) r_hi <= bus.data_out;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = '0;
      bus.MEM_V      = 1'b0;
      bus.r_w        = 1'b0;
      bus.size       = 3'd0;
      bus.address    = '0;
      bus.data_in    = '0;
      case (r_state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (w_accept) w_state_nxt = w_illegal ? S_ERR : S_RD_LO;
         end
         S_RD_LO: begin
            bus.MEM_V   = 1'b1;
            bus.size    = MEM_RD_DW;
            bus.address = w_base;
            w_state_nxt = r_cross ? S_RD_HI : (r_we ? S_WR_LO : S_RESP);
         end
         S_RD_HI: begin
            bus.MEM_V   = 1'b1;
            bus.size    = MEM_RD_DW;
            bus.address = w_base_hi;
            w_state_nxt = r_we ? S_WR_LO : S_RESP;
         end
         S_WR_LO: begin
            bus.MEM_V   = 1'b1;
            bus.r_w     = 1'b1;
            bus.size    = MEM_WR_D;
            bus.address = w_base;
            bus.data_in = w_merged[XLEN-1:0];
            w_state_nxt = r_cross ? S_WR_HI : S_RESP;
         end
         S_WR_HI: begin
            bus.MEM_V   = 1'b1;
            bus.r_w     = 1'b1;
            bus.size    = MEM_WR_D;
            bus.address = w_base_hi;
            bus.data_in = w_merged[2*XLEN-1:XLEN];
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = r_we ? '0 : w_ext;
            w_state_nxt    = S_IDLE;
         end
         S_ERR: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = 1'b1;
            w_state_nxt    = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire
